tlcd_bus_arbiter: RTL and testbench
===================================

# tlcd_bus_arbiter

Sequencer and arbiter for the shared 16x2 Text LCD bus. Two requesters, port 0 for the custom-font CGRAM loader and port 1 for the DDRAM text refresher, each present one command or data byte at a time. The block grants the bus round-robin, honours a burst lock, and generates the full HD44780 write cycle on TLCD_E/RS/RW/DATA, including the post-command busy wait. It replaces the static done-flag multiplexer at top level, so neither requester drives the pins directly.

## Interface
- SETUP_CYC, 2: cycles RS/DATA are stable before E rises.
- PULSE_CYC, 12: cycles E is high.
- HOLD_CYC, 2: cycles RS/DATA are held after E falls.
- WAIT_CYC, 2000: post-write wait for normal commands and data (40 us at 50 MHz).
- LONG_WAIT_CYC, 82000: post-write wait for clear/home (1.64 ms).
- CNT_W, 17: phase counter width. It must hold max(all *_CYC).
- CLK  in  1  single clock domain.
- RESETN  in  1  reset, synchronous and active-low.
- REQ0, REQ1  in  1  request: a byte is pending on the port.
- LOCK0, LOCK1  in  1  burst lock: reserves the bus for this port between its commands.
- RS0, RS1  in  1  register select for the pending byte (0 = instruction, 1 = data).
- DATA0, DATA1  in  8  pending byte.
- ACK0, ACK1  out  1  one-cycle pulse when the port's byte has completed, including its wait.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- OWNER  out  1  port currently or last granted.
- TLCD_E, TLCD_RS, TLCD_RW  out  1  LCD control pins. RW is constant 0 (write only).
- TLCD_DATA  out  8  LCD data bus.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE → SETUP on grant. SETUP → PULSE → HOLD → WAIT, each after its programmed cycle count. WAIT → IDLE.
- Arbitration runs only in IDLE, in this order:
  1. If the last owner's LOCK is high, only that owner may be granted. The other port waits even if the owner is not requesting.
  2. Otherwise, if exactly one port requests, grant it.
  3. If both request, grant the port that is not OWNER (round-robin).
- On grant, RS and DATA of the winner are latched into TLCD_RS and TLCD_DATA and OWNER is updated. The requester may change its inputs afterwards.
- Wait length is LONG_WAIT_CYC when the latched byte has RS = 0 and DATA is 8'h01, 8'h02 or 8'h03 (clear/home). Otherwise it is WAIT_CYC.
- TLCD_E is high only in PULSE. TLCD_RS and TLCD_DATA are held constant from SETUP through WAIT.
- ACKn is asserted during the last WAIT cycle for the owning port only. It is never asserted for both ports.
- Handshake: the requester samples ACK at the clock edge and deasserts REQ (or presents the next byte) on that edge. REQ seen in the following IDLE cycle is treated as a new request.
- A request that drops before grant is simply not served. No pending state is stored.

## Timing
- Reset values: TLCD_E = 0, TLCD_RS = 0, TLCD_RW = 0, TLCD_DATA = 8'h00, ACK0 = ACK1 = 0, BUSY = 0, OWNER = 1, FSM = IDLE, counter = 0.
- Because OWNER resets to 1, port 0 wins the first contention.
- REQ sampled high in IDLE cycle t gives this sequence:
  - SETUP in cycles t+1 … t+S.
  - E high in t+S+1 … t+S+P.
  - HOLD through t+S+P+H.
  - WAIT through t+S+P+H+W, with ACK in that last cycle.
  - IDLE at t+S+P+H+W+1.
- Command throughput is one byte per S+P+H+W+1 cycles. There is exactly one IDLE cycle between back-to-back commands.
- Synchronous reset is honoured in any state, including mid-pulse. E drops to 0 on the next edge and no ACK is issued for the aborted byte.
- LOCK is sampled only in IDLE. Changing it mid-command has no effect until the next IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared header `tlcd_defs`:
  - FSM state encodings.
  - Long-wait instruction codes (CLEAR = 8'h01, HOME = 8'h02/8'h03).
  - Default timing constants at 50 MHz.
- One sub-module, `tlcd_phase_timer`: a loadable CNT_W down-counter with load value, load strobe and an `expire` flag (counter == 1). It is shared by every phase, and the FSM reloads it at each transition.
- Expected size: FSM plus arbiter around 200 lines, timer around 40.

## Test plan
All scenarios use S = 1, P = 2, H = 1, W = 3, LW = 6.
- Single write: REQ1 with RS1 = 1, DATA1 = 8'h41 at t → TLCD_RS = 1 and TLCD_DATA = 8'h41 from t+1; E high at t+2..t+3; ACK1 at t+7; BUSY low at t+8.
- Long wait: REQ0 with RS0 = 0, DATA0 = 8'h01 → ACK0 exactly 3 cycles later than in the normal case. The same byte with RS0 = 1 uses the normal wait.
- Contention from reset: REQ0 and REQ1 both held high → grant order 0, 1, 0, 1. ACKs alternate and are never simultaneous.
- Burst lock: LOCK0 = 1 with REQ0 and REQ1 both high for 4 bytes → four consecutive ACK0 and no ACK1. With LOCK0 still high, REQ0 dropped and REQ1 high → no grant. Dropping LOCK0 → port 1 granted in the next IDLE.
- Reset mid-pulse: RESETN = 0 during PULSE → next edge gives E = 0, DATA = 8'h00, OWNER = 1, no ACK. After release, a fresh request completes normally.
- Pin check over all scenarios: TLCD_RW is always 0, and TLCD_DATA/RS never change while E = 1 or during HOLD.

Source files
------------

// File: rtl/tlcd_bus_arbiter_pkg.sv
// Shared definitions for the Text LCD bus arbiter: FSM states, long-wait codes, 50 MHz timing defaults.
package tlcd_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } tlcd_state_e;

   // Instructions that need the long post-write wait
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   // Default phase lengths in clock cycles at 50 MHz
   localparam int unsigned DEF_SETUP_CYC     = 2;
   localparam int unsigned DEF_PULSE_CYC     = 12;
   localparam int unsigned DEF_HOLD_CYC      = 2;
   localparam int unsigned DEF_WAIT_CYC      = 2000;
   localparam int unsigned DEF_LONG_WAIT_CYC = 82000;
   localparam int unsigned DEF_CNT_W         = 17;

   // One byte presented to the LCD bus
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } tlcd_byte_t;

   // Clear/home instructions take far longer for the controller to finish
   function automatic logic is_long_wait(input tlcd_byte_t b);
      return (!b.rs) && ((b.data == CMD_CLEAR) || (b.data == CMD_HOME) ||
                         (b.data == CMD_HOME_ALT));
   endfunction

endpackage

// File: rtl/tlcd_bus_arbiter_phase_timer.sv
// Loadable down-counter shared by every write-cycle phase; expire marks the final cycle of a phase.
module tlcd_phase_timer #(
   parameter int unsigned CNT_W = 17
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire_q;

   // Load on strobe, otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter and registered expire flag (high while count is one)
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= (cnt_d == CNT_W'(1));
      end
   end

   assign count_o  = cnt_q;
   assign expire_o = expire_q;

endmodule

// File: rtl/tlcd_bus_arbiter.sv
// Round-robin arbiter with burst lock for two LCD requesters, generating the HD44780 write cycle.
module tlcd_bus_arbiter
   import tlcd_bus_arbiter_pkg::*;
#(
   parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
   parameter int unsigned PULSE_CYC     = DEF_PULSE_CYC,
   parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
   parameter int unsigned WAIT_CYC      = DEF_WAIT_CYC,
   parameter int unsigned LONG_WAIT_CYC = DEF_LONG_WAIT_CYC,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       lock0_i,
   input  logic       lock1_i,
   input  logic       rs0_i,
   input  logic       rs1_i,
   input  logic [7:0] data0_i,
   input  logic [7:0] data1_i,
   output logic       ack0_o,
   output logic       ack1_o,
   output logic       busy_o,
   output logic       owner_o,
   output logic       tlcd_e_o,
   output logic       tlcd_rs_o,
   output logic       tlcd_rw_o,
   output logic [7:0] tlcd_data_o
);

   tlcd_state_e      state_q, state_d;
   tlcd_byte_t       byte_q, byte_d;
   logic             owner_q, owner_d;
   logic             e_q, e_d;
   logic             busy_q, busy_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             grant, winner, last_wait;
   logic             tmr_load, tmr_expire;
   logic [CNT_W-1:0] tmr_val, tmr_count;

   tlcd_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i      (clk_i),
      .resetn_i   (resetn_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .count_o    (tmr_count),
      .expire_o   (tmr_expire)
   );

   // Arbitration: a locked owner excludes the other port even when it is not requesting
   always_comb begin
      grant  = 1'b0;
      winner = owner_q;
      if (owner_q ? lock1_i : lock0_i) begin
         grant  = owner_q ? req1_i : req0_i;
         winner = owner_q;
      end else if (req0_i && req1_i) begin
         grant  = 1'b1;
         winner = ~owner_q;
      end else if (req0_i) begin
         grant  = 1'b1;
         winner = 1'b0;
      end else if (req1_i) begin
         grant  = 1'b1;
         winner = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and phase timer reload at every transition
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d  = ST_SETUP;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(SETUP_CYC);
            end
         end
         ST_SETUP: begin
            if (tmr_expire) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(PULSE_CYC);
            end
         end
         ST_PULSE: begin
            if (tmr_expire) begin
               state_d  = ST_HOLD;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(HOLD_CYC);
            end
         end
         ST_HOLD: begin
            if (tmr_expire) begin
               state_d  = ST_WAIT;
               tmr_load = 1'b1;
               tmr_val  = is_long_wait(byte_q) ? CNT_W'(LONG_WAIT_CYC) : CNT_W'(WAIT_CYC);
            end
         end
         ST_WAIT: begin
            if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output next values; ACK is raised for the cycle whose count will be one in WAIT
   always_comb begin
      byte_d  = byte_q;
      owner_d = owner_q;
      if ((state_q == ST_IDLE) && grant) begin
         owner_d = winner;
         byte_d  = winner ? tlcd_byte_t'{rs: rs1_i, data: data1_i}
                          : tlcd_byte_t'{rs: rs0_i, data: data0_i};
      end
      e_d       = (state_d == ST_PULSE);
      busy_d    = (state_d != ST_IDLE);
      last_wait = (state_d == ST_WAIT) &&
                  (tmr_load ? (tmr_val == CNT_W'(1)) : (tmr_count == CNT_W'(2)));
      ack0_d    = last_wait && !owner_q;
      ack1_d    = last_wait && owner_q;
   end

   // Output registers
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         byte_q  <= '0;
         owner_q <= 1'b1;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         byte_q  <= byte_d;
         owner_q <= owner_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
      end
   end

   assign ack0_o      = ack0_q;
   assign ack1_o      = ack1_q;
   assign busy_o      = busy_q;
   assign owner_o     = owner_q;
   assign tlcd_e_o    = e_q;
   assign tlcd_rs_o   = byte_q.rs;
   assign tlcd_rw_o   = 1'b0;
   assign tlcd_data_o = byte_q.data;

endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// Directed bench for tlcd_bus_arbiter with a byte scoreboard and continuous pin monitor.
module tb_tlcd_bus_arbiter;

   localparam int unsigned S  = 1;
   localparam int unsigned P  = 2;
   localparam int unsigned H  = 1;
   localparam int unsigned W  = 3;
   localparam int unsigned LW = 6;

   typedef struct {
      bit       port;
      bit       rs;
      bit [7:0] data;
      bit       lng;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
   logic       rs0 = 1'b0, rs1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, busy, owner, tlcd_e, tlcd_rs, tlcd_rw;
   logic [7:0] tlcd_data;

   exp_t sb[$];
   exp_t cur;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   tlcd_bus_arbiter #(
      .SETUP_CYC     (S),
      .PULSE_CYC     (P),
      .HOLD_CYC      (H),
      .WAIT_CYC      (W),
      .LONG_WAIT_CYC (LW),
      .CNT_W         (17)
   ) dut (
      .clk_i       (clk),
      .resetn_i    (resetn),
      .req0_i      (req0),
      .req1_i      (req1),
      .lock0_i     (lock0),
      .lock1_i     (lock1),
      .rs0_i       (rs0),
      .rs1_i       (rs1),
      .data0_i     (data0),
      .data1_i     (data1),
      .ack0_o      (ack0),
      .ack1_o      (ack1),
      .busy_o      (busy),
      .owner_o     (owner),
      .tlcd_e_o    (tlcd_e),
      .tlcd_rs_o   (tlcd_rs),
      .tlcd_rw_o   (tlcd_rw),
      .tlcd_data_o (tlcd_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit port, input bit rs, input bit [7:0] data, input bit lng);
      exp_t e;
      e.port = port;
      e.rs   = rs;
      e.data = data;
      e.lng  = lng;
      sb.push_back(e);
   endtask

   // Returns on the negedge where an ACK is visible; caller updates inputs right there
   task automatic wait_ack(input string tag);
      int n = 0;
      @(negedge clk);
      while (!(ack0 || ack1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ack_seen"}, 32'(ack0 | ack1), 32'(1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_e",     32'(tlcd_e),    32'(0));
      check("rst_rs",    32'(tlcd_rs),   32'(0));
      check("rst_rw",    32'(tlcd_rw),   32'(0));
      check("rst_data",  32'(tlcd_data), 32'(8'h00));
      check("rst_ack0",  32'(ack0),      32'(0));
      check("rst_ack1",  32'(ack1),      32'(0));
      check("rst_busy",  32'(busy),      32'(0));
      check("rst_owner", 32'(owner),     32'(1));
      resetn = 1'b1;
   endtask

   // Pin monitor: E window, RS/DATA stability, ACK exclusivity and scoreboard pops
   int   busy_cnt = 0;
   logic prev_busy = 1'b0, prev_ack = 1'b0, prev_rs = 1'b0;
   logic [7:0] prev_data = 8'h00;
   always @(negedge clk) begin
      if (mon_en) begin
         check("rw_zero", 32'(tlcd_rw), 32'(0));
         check("ack_exclusive", 32'(ack0 & ack1), 32'(0));
         if (busy) busy_cnt++; else busy_cnt = 0;
         check("e_window", 32'(tlcd_e), 32'((busy_cnt > int'(S)) && (busy_cnt <= int'(S + P))));
         if (busy && prev_busy) begin
            check("rs_stable",   32'(tlcd_rs),   32'(prev_rs));
            check("data_stable", 32'(tlcd_data), 32'(prev_data));
         end
         if (prev_ack) check("idle_after_ack", 32'(busy), 32'(0));
         if (ack0 || ack1) begin
            check("ack_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               check("ack_port",  32'(ack1),      32'(cur.port));
               check("ack_owner", 32'(owner),     32'(cur.port));
               check("ack_rs",    32'(tlcd_rs),   32'(cur.rs));
               check("ack_data",  32'(tlcd_data), 32'(cur.data));
               check("ack_cycles", 32'(busy_cnt), 32'(S + P + H + (cur.lng ? LW : W)));
            end
         end
         prev_busy = busy;
         prev_ack  = ack0 | ack1;
         prev_rs   = tlcd_rs;
         prev_data = tlcd_data;
      end
   end

   typedef struct { bit rs; bit [7:0] data; bit lng; } lw_t;
   lw_t lw_tab[5];

   initial begin
      lw_tab[0] = '{rs: 1'b0, data: 8'h01, lng: 1'b1};
      lw_tab[1] = '{rs: 1'b1, data: 8'h01, lng: 1'b0};
      lw_tab[2] = '{rs: 1'b0, data: 8'h02, lng: 1'b1};
      lw_tab[3] = '{rs: 1'b0, data: 8'h03, lng: 1'b1};
      lw_tab[4] = '{rs: 1'b0, data: 8'h04, lng: 1'b0};

      do_reset();
      mon_en = 1'b1;

      // Single data write on port 1
      push(1'b1, 1'b1, 8'h41, 1'b0);
      rs1 = 1'b1; data1 = 8'h41; req1 = 1'b1;
      wait_ack("single");
      req1 = 1'b0;

      // Long versus normal wait on port 0, back to back
      for (int i = 0; i < 5; i++) begin
         push(1'b0, lw_tab[i].rs, lw_tab[i].data, lw_tab[i].lng);
         rs0 = lw_tab[i].rs; data0 = lw_tab[i].data; req0 = 1'b1;
         wait_ack("longwait");
      end
      req0 = 1'b0;

      // Contention from reset: port 0 first, then alternating
      do_reset();
      rs0 = 1'b1; data0 = 8'h30; rs1 = 1'b1; data1 = 8'h31;
      push(1'b0, 1'b1, 8'h30, 1'b0);
      push(1'b1, 1'b1, 8'h31, 1'b0);
      push(1'b0, 1'b1, 8'h30, 1'b0);
      push(1'b1, 1'b1, 8'h31, 1'b0);
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) wait_ack("contend");
      req0 = 1'b0; req1 = 1'b0;
      check("contend_owner", 32'(owner), 32'(1));

      // Burst lock on port 0
      repeat (3) @(negedge clk);
      rs0 = 1'b1; data0 = 8'h50; rs1 = 1'b1; data1 = 8'h42;
      for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 8'h50, 1'b0);
      lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) wait_ack("burst");
      req0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("lock_holdoff", 32'(busy), 32'(0));
      end
      push(1'b1, 1'b1, 8'h42, 1'b0);
      lock0 = 1'b0;
      @(negedge clk);
      check("unlock_grant_busy",  32'(busy),  32'(1));
      check("unlock_grant_owner", 32'(owner), 32'(1));
      wait_ack("unlock");
      req1 = 1'b0;

      // Reset in the middle of the E pulse
      repeat (2) @(negedge clk);
      push(1'b0, 1'b1, 8'h55, 1'b0);
      rs0 = 1'b1; data0 = 8'h55; req0 = 1'b1;
      begin
         int n = 0;
         @(negedge clk);
         while (!tlcd_e && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      check("midpulse_e_seen", 32'(tlcd_e), 32'(1));
      resetn = 1'b0; req0 = 1'b0;
      @(negedge clk);
      check("abort_e",     32'(tlcd_e),    32'(0));
      check("abort_data",  32'(tlcd_data), 32'(8'h00));
      check("abort_owner", 32'(owner),     32'(1));
      check("abort_ack0",  32'(ack0),      32'(0));
      check("abort_busy",  32'(busy),      32'(0));
      sb.delete();
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_ack", 32'(ack0 | ack1), 32'(0));

      // Fresh request after the aborted byte
      push(1'b1, 1'b0, 8'h38, 1'b0);
      rs1 = 1'b0; data1 = 8'h38; req1 = 1'b1;
      wait_ack("fresh");
      req1 = 1'b0;

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
